alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer that shares one combinational 8-bit ALU.
- Each requester (for example, the fetch/decode path and an auxiliary address-calculation unit) submits mode + two operands with a valid/ready handshake.
- The block owns a flags register that it drives onto the ALU CFlags input, registers the result and flags, and returns them to the granted requester.
- It sits between the requesters and the ALU; no other logic drives the ALU.

Parameters:
- DATA_W, 8, operand/result width; must match ALU width.
- MODE_W, 4, ALU mode select width.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  2  per-requester request valid; bit i = requester i.
- req_ready  output  2  per-requester accept; at most one bit high.
- req_mode  input  2*MODE_W  requester i mode in slice [i*MODE_W +: MODE_W].
- req_op1  input  2*DATA_W  requester i Operand1.
- req_op2  input  2*DATA_W  requester i Operand2.
- rsp_valid  output  2  one-hot response valid to the owning requester.
- rsp_ready  input  2  per-requester response accept.
- rsp_data  output  DATA_W  registered ALU result.
- rsp_flags  output  4  registered {Z,C,S,O}.
- alu_mode  output  MODE_W  to ALU mode.
- alu_op1  output  DATA_W  to ALU Operand1.
- alu_op2  output  DATA_W  to ALU Operand2.
- alu_cflags  output  4  to ALU CFlags; equals flags register.
- alu_en  output  1  to ALU E; high only in EXEC.
- alu_out  input  DATA_W  from ALU Out.
- alu_flags  input  4  from ALU Flags.
- busy  output  1  high when state != IDLE.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- FSM states: IDLE, EXEC, RESP.
- Reset: state=IDLE; last_grant=1 (so requester 0 wins the first contention); latched mode/op1/op2=0; owner=0; flags_reg=4'b0000; rsp_data=0; rsp_flags=0. Outputs follow: req_ready=00, rsp_valid=00, alu_en=0, busy=0, alu_* = 0.
- Arbitration in IDLE (combinational):
  - If only one req_valid bit is set, grant it.
  - If both are set, grant the requester != last_grant.
  - If neither is set, no grant.
  - req_ready[g]=1 only for the grant g, and only in IDLE. Both bits are 0 in EXEC/RESP.
- Request handshake: req_valid[g] & req_ready[g] at rising edge T.
  - Latch that requester's mode/op1/op2 into internal registers.
  - owner<=g; last_grant<=g; state<=EXEC.
- Requester obligations: req_valid must not depend on req_ready; payload must be held stable while valid is high and not accepted.
- EXEC (exactly one cycle, T+1):
  - alu_mode/alu_op1/alu_op2 driven from the latched registers; alu_cflags=flags_reg; alu_en=1.
  - At the end of the cycle: rsp_data<=alu_out; rsp_flags<=alu_flags; flags_reg<=alu_flags; state<=RESP.
- ALU drive outside EXEC: alu_* hold the latched values and alu_en=0.
- RESP (from T+2):
  - rsp_valid[owner]=1, other bit 0.
  - rsp_data and rsp_flags are stable until the handshake.
  - On rsp_valid[owner] & rsp_ready[owner], state<=IDLE.
  - rsp_ready of the non-owner is ignored.
- Timing:
  - Accept-to-response latency is 2 cycles.
  - No new request is accepted in the cycle the response completes.
  - Minimum issue interval is 3 cycles per operation.
- Fairness: under continuous contention, grants alternate 0,1,0,1...
  - A requester that drops valid while not granted loses nothing; the pointer is unchanged.
- Flags:
  - flags_reg updates only in EXEC, for every mode.
  - It is never cleared except by rst.
  - It is shared between requesters (single architectural flag set).
- Width: all data paths are DATA_W; no sign or zero extension is performed in this block; alu_out is captured unchanged.
- Reset mid-operation: rst in EXEC or RESP aborts the transaction.
  - No rsp_valid is produced; flags_reg returns to 0; next cycle is IDLE with reset values.
- Simultaneous events:
  - rst has priority over any handshake.
  - req_valid asserted during EXEC/RESP is stalled (ready=0) and not lost.

Test Plan:
- Single request, requester 0: mode=0 (add), op1=0xF0, op2=0x20 → req_ready[0]=1 at T; alu_en=1 at T+1; rsp_valid=01 at T+2 with rsp_data=0x10 and rsp_flags[3]=0 (Z), [0]=1 (O from carry-out). alu_cflags equals these flags on the next EXEC.
- Zero result, requester 1: mode=1, op1=0x05, op2=0x05 → rsp_valid=10, rsp_data=0x00, rsp_flags[3]=1.
- Contention: both valid continuously from reset, requester 0 mode=2 op1=0xAA, requester 1 mode=3 op2=0x55 → responses alternate 0xAA (owner 0), 0x55 (owner 1), 0xAA..., one accept every 3 cycles when rsp_ready is tied high.
- Response backpressure: rsp_ready[0]=0 for 5 cycles → rsp_valid[0] held, rsp_data stable, req_ready=00 and busy=1 throughout; requester 1 valid stalls; IDLE is reached one cycle after rsp_ready[0]=1.
- Reset in RESP: assert rst while rsp_valid=01 → next cycle rsp_valid=00, busy=0, alu_cflags=0000, and requester 0 wins the next contention.
- Wrong-owner ready: owner=0 in RESP, rsp_ready=10 → no completion; state stays RESP.

Source files
------------

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Round-robin arbiter and sequencer that lets two requesters share a single
//   combinational ALU. A request is accepted in IDLE, the ALU is enabled for
//   exactly one EXEC cycle, and the registered result plus flags are offered
//   to the owning requester in RESP until it accepts them.
//
//   The block owns the architectural flags register: it is presented to the
//   ALU carry-in flags during EXEC and updated from the ALU flags at the end
//   of every EXEC cycle, regardless of which requester issued the operation.
//
// Ports
//   clk, rst               clock (rising edge), synchronous active-high reset
//   req_valid/req_ready    per-requester request handshake (bit i = req i)
//   req_mode/op1/op2       per-requester payload, requester i in slice i
//   rsp_valid/rsp_ready    per-requester response handshake
//   rsp_data/rsp_flags     registered ALU result and {Z,C,S,O}
//   alu_mode/op1/op2       latched operation driven to the ALU
//   alu_cflags             flags register driven to the ALU
//   alu_en                 ALU enable, high only in EXEC
//   alu_out/alu_flags      ALU result and flags
//   busy                   high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int DATA_W = 8,
  parameter int MODE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*MODE_W-1:0]   req_mode,
  input  logic [2*DATA_W-1:0]   req_op1,
  input  logic [2*DATA_W-1:0]   req_op2,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_W-1:0]     rsp_data,
  output logic [3:0]            rsp_flags,
  output logic [MODE_W-1:0]     alu_mode,
  output logic [DATA_W-1:0]     alu_op1,
  output logic [DATA_W-1:0]     alu_op2,
  output logic [3:0]            alu_cflags,
  output logic                  alu_en,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic [3:0]            alu_flags,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  logic                last_grant;
  logic                owner;
  logic [MODE_W-1:0]   mode_q;
  logic [DATA_W-1:0]   op1_q;
  logic [DATA_W-1:0]   op2_q;
  logic [3:0]          flags_reg;

  logic                grant_valid;
  logic                grant_idx;

  // Round-robin pick. A lone requester always wins; under contention the
  // requester that was not granted last time wins. The pointer only moves on
  // an actual accept, so a requester that withdraws while waiting keeps its
  // turn.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    case (req_valid)
      2'b01: begin
        grant_valid = 1'b1;
        grant_idx   = 1'b0;
      end
      2'b10: begin
        grant_valid = 1'b1;
        grant_idx   = 1'b1;
      end
      2'b11: begin
        grant_valid = 1'b1;
        grant_idx   = ~last_grant;
      end
      default: ;
    endcase
  end

  // Requests are accepted only in IDLE; a request raised during EXEC/RESP
  // simply waits with ready low.
  assign req_ready  = (state == IDLE && grant_valid)
                      ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid  = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy       = (state != IDLE);
  assign alu_en     = (state == EXEC);

  // The ALU always sees the latched operation; only alu_en qualifies it.
  assign alu_mode   = mode_q;
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_cflags = flags_reg;

  // NOTE: all state registers use non-blocking assignments so that every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      mode_q     <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      flags_reg  <= 4'b0000;
      rsp_data   <= '0;
      rsp_flags  <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            mode_q     <= grant_idx ? req_mode[2*MODE_W-1:MODE_W]
                                    : req_mode[MODE_W-1:0];
            op1_q      <= grant_idx ? req_op1[2*DATA_W-1:DATA_W]
                                    : req_op1[DATA_W-1:0];
            op2_q      <= grant_idx ? req_op2[2*DATA_W-1:DATA_W]
                                    : req_op2[DATA_W-1:0];
            owner      <= grant_idx;
            last_grant <= grant_idx;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // The flags register is one architectural flag set shared by
          // both requesters; every operation overwrites it.
          rsp_data  <= alu_out;
          rsp_flags <= alu_flags;
          flags_reg <= alu_flags;
          state     <= RESP;
        end
        RESP: begin
          // Only the owner can retire the response; the other ready bit is
          // ignored. No accept happens in this cycle since state != IDLE.
          if (rsp_ready[owner]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Self-checking bench for alu_arbiter. A behavioural 8-bit ALU stands in
//   for the real one. Expected grants, results and flags come from a
//   transaction-level model: the round-robin pointer, the architectural
//   flag set, and the ALU function applied to each submitted operation.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_mode;
  logic [15:0] req_op1;
  logic [15:0] req_op2;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [7:0]  rsp_data;
  logic [3:0]  rsp_flags;
  logic [3:0]  alu_mode;
  logic [7:0]  alu_op1;
  logic [7:0]  alu_op2;
  logic [3:0]  alu_cflags;
  logic        alu_en;
  logic [7:0]  alu_out;
  logic [3:0]  alu_flags;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Transaction-level model state.
  logic [3:0] exp_flags;
  logic       exp_last;

  alu_arbiter #(.DATA_W(8), .MODE_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_flags  (rsp_flags),
    .alu_mode   (alu_mode),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_cflags (alu_cflags),
    .alu_en     (alu_en),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .busy       (busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Behavioural ALU: returns {Z,C,S,O, result}. O reports the carry/borrow
  // out, mode 7 adds the incoming O flag as carry-in.
  function automatic logic [11:0] ref_alu(input logic [3:0] m, input logic [7:0] a,
                                          input logic [7:0] b, input logic [3:0] cf);
    logic [8:0] r;
    case (m[2:0])
      3'd0:    r = {1'b0, a} + {1'b0, b};
      3'd1:    r = {1'b0, a} - {1'b0, b};
      3'd2:    r = {1'b0, a};
      3'd3:    r = {1'b0, b};
      3'd4:    r = {1'b0, a & b};
      3'd5:    r = {1'b0, a | b};
      3'd6:    r = {1'b0, a ^ b};
      default: r = {1'b0, a} + {1'b0, b} + {8'd0, cf[0]};
    endcase
    return {(r[7:0] == 8'd0), r[8], r[7], r[8], r[7:0]};
  endfunction

  assign {alu_flags, alu_out} = ref_alu(alu_mode, alu_op1, alu_op2, alu_cflags);

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_mode  = '0;
    req_op1   = '0;
    req_op2   = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    exp_flags = 4'b0000;
    exp_last  = 1'b1;
  endtask

  // One complete operation. Starts with the DUT idle and req_valid low,
  // ends at the negedge after the response has retired.
  task automatic do_op(input logic [1:0] valid, input logic [3:0] m0, input logic [3:0] m1,
                       input logic [7:0] a0, input logic [7:0] b0,
                       input logic [7:0] a1, input logic [7:0] b1,
                       input int bp, input string tag,
                       output logic gw, output logic [7:0] gd, output logic [3:0] gf);
    logic       g;
    logic [1:0] oh;
    logic [3:0] m;
    logic [7:0] a, b, ed;
    logic [3:0] ef;
    g  = (valid == 2'b11) ? ~exp_last : valid[1];
    oh = g ? 2'b10 : 2'b01;
    m  = g ? m1 : m0;
    a  = g ? a1 : a0;
    b  = g ? b1 : b0;
    {ef, ed} = ref_alu(m, a, b, exp_flags);
    gw = g;

    @(posedge clk); #1;
    req_mode  = {m1, m0};
    req_op1   = {a1, a0};
    req_op2   = {b1, b0};
    req_valid = valid;
    rsp_ready = 2'b00;
    @(negedge clk);
    checks++;
    if ({req_ready, busy} !== {oh, 1'b0}) begin
      errors++;
      $display("FAIL %s_grant: req_ready,busy=%b,%b expected %b,0", tag, req_ready, busy, oh);
    end

    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({alu_en, busy, req_ready, rsp_valid} !== {1'b1, 1'b1, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL %s_exec_ctrl: en,busy,rdy,rv=%b,%b,%b,%b expected 1,1,00,00",
               tag, alu_en, busy, req_ready, rsp_valid);
    end
    checks++;
    if ({alu_mode, alu_op1, alu_op2, alu_cflags} !== {m, a, b, exp_flags}) begin
      errors++;
      $display("FAIL %s_exec_drive: mode,op1,op2,cflags=%h,%h,%h,%b expected %h,%h,%h,%b",
               tag, alu_mode, alu_op1, alu_op2, alu_cflags, m, a, b, exp_flags);
    end

    // Backpressure: only the non-owner's ready is raised, which must be ignored.
    @(posedge clk); #1;
    rsp_ready = ~oh;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready, busy, alu_en, rsp_data, rsp_flags} !==
          {oh, 2'b00, 1'b1, 1'b0, ed, ef}) begin
        errors++;
        $display("FAIL %s_resp_hold: rv,rdy,busy,en,data,flags=%b,%b,%b,%b,%h,%b expected %b,00,1,0,%h,%b",
                 tag, rsp_valid, req_ready, busy, alu_en, rsp_data, rsp_flags, oh, ed, ef);
      end
      @(posedge clk); #1;
    end
    rsp_ready = oh;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data, rsp_flags} !== {oh, ed, ef}) begin
      errors++;
      $display("FAIL %s_resp: rv,data,flags=%b,%h,%b expected %b,%h,%b",
               tag, rsp_valid, rsp_data, rsp_flags, oh, ed, ef);
    end
    gd = rsp_data;
    gf = rsp_flags;

    @(posedge clk); #1;
    rsp_ready = 2'b00;
    @(negedge clk);
    checks++;
    if ({busy, rsp_valid, alu_en} !== {1'b0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL %s_retire: busy,rv,en=%b,%b,%b expected 0,00,0", tag, busy, rsp_valid, alu_en);
    end
    exp_flags = ef;
    exp_last  = g;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({req_ready, rsp_valid, alu_en, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rdy,rv,en,busy=%b,%b,%b,%b expected 00,00,0,0",
               req_ready, rsp_valid, alu_en, busy);
    end
    checks++;
    if ({alu_mode, alu_op1, alu_op2, alu_cflags, rsp_data, rsp_flags} !== 36'd0) begin
      errors++;
      $display("FAIL reset_data: mode,op1,op2,cf,data,flags=%h,%h,%h,%b,%h,%b expected all zero",
               alu_mode, alu_op1, alu_op2, alu_cflags, rsp_data, rsp_flags);
    end
  endtask

  task automatic test_single_req0();
    logic gw; logic [7:0] gd; logic [3:0] gf;
    do_op(2'b01, 4'd0, 4'd0, 8'hF0, 8'h20, 8'h00, 8'h00, 0, "single0", gw, gd, gf);
    checks++;
    if ({gw, gd, gf} !== {1'b0, 8'h10, 4'b0101}) begin
      errors++;
      $display("FAIL single0_result: owner,data,flags=%b,%h,%b expected 0,10,0101", gw, gd, gf);
    end
  endtask

  task automatic test_zero_req1();
    logic gw; logic [7:0] gd; logic [3:0] gf;
    // The EXEC check inside do_op also confirms cflags carries 0101 from
    // the previous add.
    do_op(2'b10, 4'd0, 4'd1, 8'h00, 8'h00, 8'h05, 8'h05, 2, "zero1", gw, gd, gf);
    checks++;
    if ({gw, gd, gf[3]} !== {1'b1, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL zero1_result: owner,data,Z=%b,%h,%b expected 1,00,1", gw, gd, gf[3]);
    end
  endtask

  task automatic test_contention();
    int   last_acc = -1;
    int   accepts  = 0;
    logic nxt      = 1'b0;
    logic own_q[$];
    logic o;
    apply_reset();
    req_mode  = {4'd3, 4'd2};
    req_op1   = {8'($urandom), 8'hAA};
    req_op2   = {8'h55, 8'($urandom)};
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (req_ready !== 2'b00) begin
        checks++;
        if (req_ready !== (nxt ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL contention_grant: cycle %0d req_ready=%b expected %b",
                   cyc, req_ready, nxt ? 2'b10 : 2'b01);
        end
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 3) begin
            errors++;
            $display("FAIL contention_interval: %0d cycles between accepts expected 3", cyc - last_acc);
          end
        end
        last_acc = cyc;
        own_q.push_back(nxt);
        nxt = ~nxt;
        accepts++;
      end
      if (rsp_valid !== 2'b00) begin
        o = (own_q.size() > 0) ? own_q.pop_front() : 1'b0;
        checks++;
        if ({rsp_valid, rsp_data} !== {(o ? 2'b10 : 2'b01), (o ? 8'h55 : 8'hAA)}) begin
          errors++;
          $display("FAIL contention_resp: cycle %0d rv,data=%b,%h expected %b,%h",
                   cyc, rsp_valid, rsp_data, o ? 2'b10 : 2'b01, o ? 8'h55 : 8'hAA);
        end
      end
      @(negedge clk); #1;
    end
    checks++;
    if (accepts != 7) begin
      errors++;
      $display("FAIL contention_count: %0d accepts in 20 cycles expected 7", accepts);
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure();
    logic [3:0] m0, m1, ef;
    logic [7:0] a0, b0, a1, b1, ed;
    logic gw; logic [7:0] gd; logic [3:0] gf;
    apply_reset();
    m0 = 4'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
    m1 = 4'd4;         a1 = 8'($urandom); b1 = 8'($urandom);
    {ef, ed} = ref_alu(m0, a0, b0, exp_flags);
    req_mode  = {m1, m0};
    req_op1   = {a1, a0};
    req_op2   = {b1, b0};
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL bp_first_grant: req_ready=%b expected 01", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 2'b10;
    @(negedge clk);
    checks++;
    if ({alu_en, req_ready} !== {1'b1, 2'b00}) begin
      errors++;
      $display("FAIL bp_exec_stall: en,rdy=%b,%b expected 1,00", alu_en, req_ready);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready, busy, rsp_data, rsp_flags} !== {2'b01, 2'b00, 1'b1, ed, ef}) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d rv,rdy,busy,data,flags=%b,%b,%b,%h,%b expected 01,00,1,%h,%b",
                 i, rsp_valid, req_ready, busy, rsp_data, rsp_flags, ed, ef);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready} !== {2'b01, 2'b00}) begin
      errors++;
      $display("FAIL bp_complete_cycle: rv,rdy=%b,%b expected 01,00", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    @(negedge clk);
    checks++;
    if ({busy, req_ready} !== {1'b0, 2'b10}) begin
      errors++;
      $display("FAIL bp_idle: busy,rdy=%b,%b expected 0,10", busy, req_ready);
    end
    exp_flags = ef;
    exp_last  = 1'b0;
    req_valid = 2'b00;
    do_op(2'b10, m0, m1, a0, b0, a1, b1, 1, "bp_req1", gw, gd, gf);
  endtask

  task automatic test_reset_mid_op();
    logic [3:0] ef;
    logic [7:0] ed;
    // Reset in RESP with requester 0 as owner and as last grant.
    {ef, ed} = ref_alu(4'd2, 8'h80, 8'h00, exp_flags);
    @(posedge clk); #1;
    req_mode  = {4'd0, 4'd2};
    req_op1   = {8'h00, 8'h80};
    req_op2   = 16'h0000;
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data, rsp_flags, alu_cflags} !== {2'b01, ed, ef, ef}) begin
      errors++;
      $display("FAIL rstresp_pre: rv,data,flags,cf=%b,%h,%b,%b expected 01,%h,%b,%b",
               rsp_valid, rsp_data, rsp_flags, alu_cflags, ed, ef, ef);
    end
    rst       = 1'b1;
    rsp_ready = 2'b01;
    @(posedge clk); #1;
    rst       = 1'b0;
    rsp_ready = 2'b00;
    req_valid = 2'b11;
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy, alu_cflags, rsp_data, alu_op1} !== {2'b00, 1'b0, 4'b0000, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL rstresp_post: rv,busy,cf,data,op1=%b,%b,%b,%h,%h expected 00,0,0000,00,00",
               rsp_valid, busy, alu_cflags, rsp_data, alu_op1);
    end
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rstresp_grant: req_ready=%b expected 01", req_ready);
    end
    // That grant is taken; reset again while it is in EXEC.
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({alu_en, alu_cflags} !== {1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL rstexec_pre: en,cf=%b,%b expected 1,0000", alu_en, alu_cflags);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy, alu_cflags, rsp_data} !== {2'b00, 1'b0, 4'b0000, 8'h00}) begin
      errors++;
      $display("FAIL rstexec_post: rv,busy,cf,data=%b,%b,%b,%h expected 00,0,0000,00",
               rsp_valid, busy, alu_cflags, rsp_data);
    end
    exp_flags = 4'b0000;
    exp_last  = 1'b1;
  endtask

  task automatic test_random();
    logic [1:0] v;
    logic gw; logic [7:0] gd; logic [3:0] gf;
    for (int n = 0; n < 30; n++) begin
      v = 2'($urandom_range(1, 3));
      do_op(v, 4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), "random", gw, gd, gf);
    end
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_zero_req1();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
